// File: rtl/or_bus_arbiter.sv
// Purpose : round-robin owner selection for the shared wired-OR data bus. Only the owner's
//           word reaches Bus_Data, and every non-granted master is masked to zero.
// Latency : a request seen before edge k gives a Grant after edge k when the bus is idle.
//           Between two owners there is always exactly one Grant=0 (TURN) cycle.
// Backpr. : a requester holds Req until it is granted. The owner is released by Done,
//           by dropping Req, or by the hold timeout.
// Ports   : Clock, Reset_n (async, active-low).
//           Req/Done       per-master request level and end-of-transfer pulse.
//           Master_Data    packed words; master i is at [i*NrOfBits +: NrOfBits].
//           Grant          registered one-hot grant.
//           Bus_Data       combinational OR of the granted word.
//           Busy           high while a master owns the bus.
//           Timeout        one-cycle pulse when the hold counter revokes a grant.
module or_bus_arbiter #(
   parameter int NrOfMasters = 4,
   parameter int NrOfBits    = 32,
   parameter int MaxHold     = 16
) (
   input  logic                            Clock,
   input  logic                            Reset_n,
   input  logic [NrOfMasters-1:0]          Req,
   input  logic [NrOfMasters-1:0]          Done,
   input  logic [NrOfMasters*NrOfBits-1:0] Master_Data,
   output logic [NrOfMasters-1:0]          Grant,
   output logic [NrOfBits-1:0]             Bus_Data,
   output logic                            Busy,
   output logic                            Timeout
);

   localparam int PtrW  = (NrOfMasters > 1) ? $clog2(NrOfMasters) : 1;
   localparam int HoldW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
   localparam logic [HoldW-1:0] HoldLast = (MaxHold > 0) ? HoldW'(MaxHold - 1) : '0;
   localparam logic [HoldW-1:0] HoldSat  = '1;
   localparam logic [PtrW-1:0]  PtrLast  = PtrW'(NrOfMasters - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} state_e;

   state_e                 state_q, state_d;
   logic [NrOfMasters-1:0] grant_q, grant_d;
   logic [PtrW-1:0]        owner_q, owner_d;
   logic [PtrW-1:0]        ptr_q, ptr_d;
   logic [HoldW-1:0]       hold_q, hold_d;
   logic                   timeout_q, timeout_d;

   logic [PtrW-1:0]        cand [NrOfMasters];
   logic                   win_vld;
   logic [PtrW-1:0]        win_idx;
   logic                   own_done, own_req, hold_exp;

   // Candidates in search order: ptr, ptr+1, ... wrapping. The search walks from the far end
   // back toward ptr, so the last hit is the requester closest to ptr.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NrOfMasters; k++) begin
         cand[k] = PtrW'((int'(ptr_q) + k) % NrOfMasters);
      end
      for (int k = NrOfMasters - 1; k >= 0; k--) begin
         if (Req[cand[k]]) begin
            win_vld = 1'b1;
            win_idx = cand[k];
         end
      end
   end

   assign own_done = Done[owner_q];
   assign own_req  = Req[owner_q];
   assign hold_exp = (MaxHold != 0) && (hold_q == HoldLast);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_TURN: begin
            grant_d = '0;
            state_d = ST_IDLE;
            if (win_vld) begin
               state_d          = ST_OWN;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               hold_d           = '0;
            end
         end
         ST_OWN: begin
            hold_d = (hold_q == HoldSat) ? hold_q : hold_q + 1'b1;
            if (own_done || !own_req || hold_exp) begin
               state_d   = ST_TURN;
               grant_d   = '0;
               ptr_d     = (owner_q == PtrLast) ? '0 : owner_q + 1'b1;
               // Only a release caused by the counter alone is reported as a timeout.
               timeout_d = !own_done && own_req;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   // Masking happens here, so the downstream OR only ever sees the owner's word.
   always_comb begin
      Bus_Data = '0;
      for (int i = 0; i < NrOfMasters; i++) begin
         if (grant_q[i]) begin
            Bus_Data = Bus_Data | Master_Data[i*NrOfBits +: NrOfBits];
         end
      end
   end

   assign Grant   = grant_q;
   assign Busy    = (state_q == ST_OWN);
   assign Timeout = timeout_q;

endmodule
